apb_i2c_host_arbiter: RTL and testbench

- Two-port APB master that shares the single APB slave port of the APB-to-I2C bridge between two requesters (port 0: CPU config path, port 1: DMA/sequencer path).
- Accepts simple req/done transactions from each requester and runs one full APB transfer at a time (SETUP then ACCESS, waiting on PREADY).
- Arbitrates round-robin and rejects writes to non-writable bridge registers.
- Aborts transfers whose PREADY never arrives, using a timeout.

---
 rtl/apb_i2c_host_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_apb_i2c_host_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_host_arbiter.sv
// rtl/apb_i2c_host_arbiter.sv - two-port round-robin APB master for the I2C bridge
// Runs one SETUP/ACCESS transfer at a time, rejects illegal writes, aborts on PREADY timeout.
module apb_i2c_host_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, REJECT} state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic                elig0, elig1, pick, win_write;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(0)) || (a == ADDR_W'(1)) ||
               (a == ADDR_W'(2)) || (a == ADDR_W'(4));
    endfunction

    // A port whose done is pulsing this cycle is still dropping its req; ignore it once.
    always_comb begin
        elig0     = req0 & ~done0_q;
        elig1     = req1 & ~done1_q;
        pick      = (elig0 && elig1) ? ~last_q : elig1;
        win_write = pick ? write1 : write0;
        win_addr  = pick ? addr1  : addr0;
        win_wdata = pick ? wdata1 : wdata0;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    gnt_d    = pick;
                    last_d   = pick;
                    cnt_d    = 8'd0;
                    pwrite_d = win_write;
                    paddr_d  = win_addr;
                    pwdata_d = win_wdata;
                    if (win_write && !writable(win_addr)) begin
                        state_d = REJECT;
                    end else begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY || cnt_q == TIMEOUT_M1) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (gnt_q) begin
                        done1_d = 1'b1;
                        err1_d  = ~PREADY;
                        if (!PREADY)       rdata1_d = '0;
                        else if (!pwrite_q) rdata1_d = PRDATA;
                    end else begin
                        done0_d = 1'b1;
                        err0_d  = ~PREADY;
                        if (!PREADY)       rdata0_d = '0;
                        else if (!pwrite_q) rdata0_d = PRDATA;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            REJECT: begin
                state_d = IDLE;
                if (gnt_q) begin
                    done1_d = 1'b1;
                    err1_d  = 1'b1;
                end else begin
                    done0_d = 1'b1;
                    err0_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= 8'd0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign PSELx   = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_apb_i2c_host_arbiter.sv
// tb/tb_apb_i2c_host_arbiter.sv - self-checking bench for apb_i2c_host_arbiter
// Directed and random transactions compared against a transaction-level model.
module tb_apb_i2c_host_arbiter;
    localparam int TO = 16;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       req0, req1, write0, write1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       PSELx, PENABLE, PWRITE, PREADY;
    logic [7:0] PADDR, PWDATA, PRDATA;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mdl_rdata [2];

    apb_i2c_host_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        req0 = 0; req1 = 0; write0 = 0; write1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        PRDATA = 0; PREADY = 0;
        mdl_rdata[0] = 8'h00;
        mdl_rdata[1] = 8'h00;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    // Called at a negedge. Cycle 0 is the cycle in which req first becomes visible.
    task automatic run_txn(input string tag, input int p, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input int waits, input logic [7:0] prd);
        bit   rej, tmo, shape_ok, other_ok;
        int   exp_done, done_at, acc;
        logic got_err;
        logic [7:0] got_rd;
        rej      = wr && !(a inside {8'h00, 8'h01, 8'h02, 8'h04});
        tmo      = !rej && (waits >= TO);
        exp_done = rej ? 2 : (tmo ? 2 + TO : 3 + waits);
        done_at  = -1; acc = 0; shape_ok = 1; other_ok = 1;
        got_err  = 1'bx; got_rd = 8'hxx;
        PRDATA   = prd;
        if (p == 0) begin req0 = 1; write0 = wr; addr0 = a; wdata0 = d; end
        else        begin req1 = 1; write1 = wr; addr1 = a; wdata1 = d; end
        for (int n = 1; n <= TO + 12 && done_at < 0; n++) begin
            @(negedge PCLK);
            if (PSELx !== (!rej && n < exp_done)) shape_ok = 0;
            if (PENABLE !== (!rej && n >= 2 && n < exp_done)) shape_ok = 0;
            if (PSELx && (PADDR !== a || PWRITE !== wr || PWDATA !== d)) shape_ok = 0;
            if (PSELx && PENABLE) begin
                PREADY = (acc >= waits);
                acc++;
            end else begin
                PREADY = 1'($urandom);
            end
            if ((p == 0) ? done1 : done0) other_ok = 0;
            if ((p == 0) ? done0 : done1) begin
                done_at = n;
                got_err = (p == 0) ? err0 : err1;
                got_rd  = (p == 0) ? rdata0 : rdata1;
                req0 = 0; req1 = 0;
            end
        end
        req0 = 0; req1 = 0;
        if (tmo) mdl_rdata[p] = 8'h00;
        else if (!rej && !wr) mdl_rdata[p] = prd;
        chk({tag, "_latency"}, done_at, exp_done);
        chk({tag, "_err"}, {31'd0, got_err}, {31'd0, rej || tmo});
        chk({tag, "_rdata"}, {24'd0, got_rd}, {24'd0, mdl_rdata[p]});
        chk({tag, "_bus"}, {31'd0, shape_ok}, 32'd1);
        chk({tag, "_other_done"}, {31'd0, other_ok}, 32'd1);
        repeat (1 + $urandom_range(0, 2)) @(negedge PCLK);
    endtask

    initial begin
        int   grants[$];
        int   ndone, hit;
        bit   gap_ok, prev_psel;
        int   p, sel, r, waits;
        logic wr;
        logic [7:0] a;

        PRESETn = 1'b0;
        req0 = 0; req1 = 0; write0 = 0; write1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        PRDATA = 0; PREADY = 0;
        repeat (2) @(negedge PCLK);
        chk("reset_outs", {PSELx, PENABLE, PWRITE, done0, done1, err0, err1},
            7'b0);
        chk("reset_bus", {8'd0, PADDR, PWDATA, rdata0}, 32'd0);
        chk("reset_rdata1", {24'd0, rdata1}, 32'd0);
        do_reset();

        run_txn("rd0_a02", 0, 1'b0, 8'h02, 8'h00, 0, 8'h5A);
        run_txn("wr1_rej", 1, 1'b1, 8'h03, 8'hFF, 0, 8'h00);
        run_txn("wr0_wait5", 0, 1'b1, 8'h04, 8'h81, 5, 8'hEE);
        run_txn("rd1_wait15", 1, 1'b0, 8'h07, 8'h00, TO - 1, 8'h3C);
        run_txn("rd0_timeout", 0, 1'b0, 8'h01, 8'h00, 255, 8'h99);
        run_txn("rd0_after_to", 0, 1'b0, 8'h01, 8'h00, 0, 8'hC3);

        for (int i = 0; i < 40; i++) begin
            p   = $urandom_range(0, 1);
            wr  = 1'($urandom);
            sel = $urandom_range(0, 7);
            a   = (sel < 6) ? 8'(sel) : 8'($urandom);
            r   = $urandom_range(0, 9);
            waits = (r == 9) ? TO + $urandom_range(0, 3) :
                    (r < 5)  ? 0 : $urandom_range(1, TO - 1);
            run_txn($sformatf("rand%0d", i), p, wr, a, 8'($urandom), waits, 8'($urandom));
        end

        do_reset();
        req0 = 1; write0 = 0; addr0 = 8'h10;
        req1 = 1; write1 = 0; addr1 = 8'h20;
        PRDATA = 8'h33; PREADY = 1;
        ndone = 0; gap_ok = 1; prev_psel = 0;
        for (int n = 0; n < 80 && ndone < 6; n++) begin
            @(negedge PCLK);
            if (PSELx && !PENABLE) begin
                if (prev_psel) gap_ok = 0;
                grants.push_back((PADDR == 8'h20) ? 1 : 0);
                if (grants.size() == 6) begin req0 = 0; req1 = 0; end
            end
            if (done0) ndone++;
            if (done1) ndone++;
            prev_psel = PSELx;
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 6; i++)
            chk($sformatf("rr_grant%0d", i), (i < grants.size()) ? grants[i] : 9, i % 2);
        chk("rr_gap", {31'd0, gap_ok}, 32'd1);
        chk("rr_done_count", ndone, 6);
        repeat (3) @(negedge PCLK);

        req1 = 1; write1 = 0; addr1 = 8'h01; PREADY = 0;
        hit = 0;
        for (int n = 0; n < 10 && !hit; n++) begin
            @(negedge PCLK);
            if (PSELx && PENABLE) hit = 1;
        end
        chk("rst_reached_access", hit, 1);
        PRESETn = 1'b0;
        #1;
        chk("rst_mid_outs", {28'd0, PSELx, PENABLE, done0, done1}, 32'd0);
        req1 = 0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        req0 = 1; addr0 = 8'h11; req1 = 1; addr1 = 8'h22; PREADY = 1;
        hit = 0;
        for (int n = 1; n < 10 && hit == 0; n++) begin
            @(negedge PCLK);
            if (PSELx && !PENABLE) begin
                hit = n;
                req0 = 0; req1 = 0;
                chk("rst_first_winner", {24'd0, PADDR}, 32'h11);
            end
        end
        chk("rst_first_setup_cycle", hit, 1);
        req0 = 0; req1 = 0;
        repeat (6) @(negedge PCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
